// File: rtl/sirv_reset_seq_sync_pkg.sv
// Shared definitions for the perips reset sequencer: FSM state encoding and
// small elaboration-time helpers used to size counters.
package sirv_reset_seq_sync_pkg;

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_STRETCH = 3'd1,
        ST_REL     = 3'd2,
        ST_GAP     = 3'd3,
        ST_DONE    = 3'd4
    } seq_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Index width for a channel pointer; a single channel still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sirv_reset_sync_chain.sv
// Reset catch/synchroniser: asserts immediately with rst_n, releases
// SYNC_STAGES clock edges after rst_n rises.
module sirv_reset_sync_chain
    import sirv_reset_seq_sync_pkg::*;
#(
    parameter int SYNC_STAGES = 3
) (
    input  logic clk,
    input  logic rst_n,
    output logic sync_ok
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift a constant 1 through the chain; async clear keeps assertion glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_ok = chain[SYNC_STAGES-1];

endmodule

// File: rtl/sirv_reset_seq_sync.sv
// Reset sequencer for the perips reset tree: synchronised release, a minimum
// stretch, then one-at-a-time release of NUM_CH active-low resets with a gap,
// per-channel hold-off, software re-reset and a DFT bypass.
module sirv_reset_seq_sync
    import sirv_reset_seq_sync_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int SYNC_STAGES = 3,
    parameter int STRETCH     = 16,
    parameter int GAP         = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              test_mode,
    input  logic              sw_rst_req,
    input  logic [NUM_CH-1:0] ch_hold_i,
    output logic [NUM_CH-1:0] rst_n_o,
    output logic              seq_busy,
    output logic              seq_done
);

    localparam int CNT_W = $clog2(max_int(STRETCH, GAP) + 1);
    localparam int IDX_W = idx_width(NUM_CH);

    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH - 1);
    // GAP==0 never enters ST_GAP, so the bound is only meaningful for GAP>0.
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_CH - 1);

    seq_state_e        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [NUM_CH-1:0] rst_q, rst_q_nxt;
    logic              sync_ok;
    logic              cur_hold;
    logic [NUM_CH-1:0] cur_mask;

    sirv_reset_sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .sync_ok (sync_ok)
    );

    // Decode the current channel pointer into its hold bit and a one-hot release mask.
    always_comb begin
        cur_hold = 1'b0;
        cur_mask = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_hold    = ch_hold_i[k];
                cur_mask[k] = 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_HOLD;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter, channel pointer and registered reset outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            idx   <= '0;
            rst_q <= '0;
        end else begin
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            rst_q <= rst_q_nxt;
        end
    end

    // Next-state logic; a software re-reset outranks any release on the same edge.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        rst_q_nxt = rst_q;
        if (sw_rst_req && (state != ST_HOLD)) begin
            state_nxt = ST_STRETCH;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            rst_q_nxt = '0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (sync_ok) begin
                        state_nxt = ST_STRETCH;
                        cnt_nxt   = '0;
                    end
                end
                ST_STRETCH: begin
                    if (cnt == STRETCH_LAST) begin
                        state_nxt = ST_REL;
                        cnt_nxt   = '0;
                        idx_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_REL: begin
                    if (!cur_hold) begin
                        rst_q_nxt = rst_q | cur_mask;
                        if (idx == IDX_LAST) begin
                            state_nxt = ST_DONE;
                        end else if (GAP == 0) begin
                            idx_nxt = idx + IDX_W'(1);
                        end else begin
                            state_nxt = ST_GAP;
                            cnt_nxt   = '0;
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state_nxt = ST_REL;
                        cnt_nxt   = '0;
                        idx_nxt   = idx + IDX_W'(1);
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_nxt = ST_DONE;
                end
                default: begin
                    state_nxt = ST_HOLD;
                end
            endcase
        end
    end

    // Status outputs and the DFT bypass mux on the reset vector.
    always_comb begin
        seq_busy = (state == ST_STRETCH) || (state == ST_REL) || (state == ST_GAP);
        seq_done = (state == ST_DONE);
        rst_n_o  = test_mode ? {NUM_CH{rst_n}} : rst_q;
    end

endmodule

// File: tb/tb_sirv_reset_seq_sync.sv
// Bench for sirv_reset_seq_sync: three configurations (default, GAP=0,
// NUM_CH=1) share stimulus; a release-time model predicts every output.
module tb_sirv_reset_seq_sync;

    localparam int STRETCH = 16;
    localparam int SYNC    = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       test_mode;
    logic       sw_rst_req;
    logic [2:0] ch_hold;
    logic [2:0] o0, o1;
    logic [0:0] o2;
    logic [2:0] busy_v, done_v;

    int n_chk  = 0;
    int n_pass = 0;
    int e;

    always #5 clk = ~clk;

    sirv_reset_seq_sync #(.NUM_CH(3), .SYNC_STAGES(3), .STRETCH(16), .GAP(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .test_mode(test_mode), .sw_rst_req(sw_rst_req),
        .ch_hold_i(ch_hold), .rst_n_o(o0), .seq_busy(busy_v[0]), .seq_done(done_v[0]));

    sirv_reset_seq_sync #(.NUM_CH(3), .SYNC_STAGES(3), .STRETCH(16), .GAP(0)) u_gap0 (
        .clk(clk), .rst_n(rst_n), .test_mode(test_mode), .sw_rst_req(sw_rst_req),
        .ch_hold_i(ch_hold), .rst_n_o(o1), .seq_busy(busy_v[1]), .seq_done(done_v[1]));

    sirv_reset_seq_sync #(.NUM_CH(1), .SYNC_STAGES(3), .STRETCH(16), .GAP(4)) u_one (
        .clk(clk), .rst_n(rst_n), .test_mode(test_mode), .sw_rst_req(sw_rst_req),
        .ch_hold_i(ch_hold[0:0]), .rst_n_o(o2), .seq_busy(busy_v[2]), .seq_done(done_v[2]));

    function automatic int nch(input int i);
        return (i == 2) ? 1 : 3;
    endfunction

    function automatic int gp(input int i);
        return (i == 1) ? 0 : 4;
    endfunction

    // Reference model: each channel's release edge is the first edge at or
    // after its earliest slot (stretch end or previous release + gap + 1)
    // on which its hold bit is low.
    int m_n = 0;
    int m_hi;
    bit m_started;
    int m_s[3];
    int m_rel[3][3];
    bit m_relv[3][3];

    always @(posedge clk or negedge rst_n) begin : model
        int nxt;
        int earliest;
        if (!rst_n) begin
            m_hi      = 0;
            m_started = 0;
            for (int i = 0; i < 3; i++)
                for (int k = 0; k < 3; k++) m_relv[i][k] = 0;
        end else begin
            m_n++;
            if (m_started) begin
                for (int i = 0; i < 3; i++) begin
                    if (sw_rst_req) begin
                        m_s[i] = m_n;
                        for (int k = 0; k < 3; k++) m_relv[i][k] = 0;
                    end else begin
                        nxt = nch(i);
                        for (int k = nch(i) - 1; k >= 0; k--)
                            if (!m_relv[i][k]) nxt = k;
                        if (nxt < nch(i)) begin
                            if (nxt == 0) earliest = m_s[i] + STRETCH + 1;
                            else          earliest = m_rel[i][nxt-1] + gp(i) + 1;
                            if (m_n >= earliest && !ch_hold[nxt]) begin
                                m_rel[i][nxt]  = m_n;
                                m_relv[i][nxt] = 1;
                            end
                        end
                    end
                end
            end
            if (m_hi <= SYNC) m_hi++;
            if (m_hi == SYNC + 1 && !m_started) begin
                m_started = 1;
                for (int i = 0; i < 3; i++) m_s[i] = m_n;
            end
        end
    end

    function automatic logic [2:0] exp_o(input int i);
        logic [2:0] v;
        v = '0;
        for (int k = 0; k < nch(i); k++) v[k] = test_mode ? rst_n : m_relv[i][k];
        return v;
    endfunction

    function automatic logic exp_done(input int i);
        return m_started && m_relv[i][nch(i)-1];
    endfunction

    function automatic logic [2:0] dut_o(input int i);
        case (i)
            0:       return o0;
            1:       return o1;
            default: return {2'b00, o2};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s.rst_n_o[%0d]", tag, i), dut_o(i), exp_o(i));
            chk($sformatf("%s.busy[%0d]", tag, i), {2'b00, busy_v[i]},
                {2'b00, m_started && !exp_done(i)});
            chk($sformatf("%s.done[%0d]", tag, i), {2'b00, done_v[i]}, {2'b00, exp_done(i)});
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Advance to just after edge `target`, checking the model at every edge.
    task automatic run_to(input int target, input string tag);
        while (e < target) begin
            step();
            e++;
            check_all($sformatf("%s@%0d", tag, e));
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        test_mode  = 1'b0;
        sw_rst_req = 1'b0;
        ch_hold    = 3'b000;
        repeat (3) step();
        check_all("reset");
        chk("reset.o0", o0, 3'b000);

        // Plain sequence, then software re-reset from DONE.
        rst_n = 1'b1;
        e = -1;
        run_to(2, "t1");   chk("t1.busy@2", {2'b0, busy_v[0]}, 3'b000);
        run_to(3, "t1");   chk("t1.busy@3", {2'b0, busy_v[0]}, 3'b001);
        run_to(19, "t1");  chk("t1.o0@19", o0, 3'b000);
        run_to(20, "t1");  chk("t1.o0@20", o0, 3'b001);
        chk("t6.gap0@20", o1, 3'b001); chk("t6.one@20", {2'b0, o2}, 3'b001);
        run_to(21, "t1");  chk("t6.gap0@21", o1, 3'b011);
        run_to(22, "t1");  chk("t6.gap0@22", o1, 3'b111);
        run_to(24, "t1");  chk("t1.o0@24", o0, 3'b001);
        run_to(25, "t1");  chk("t1.o0@25", o0, 3'b011);
        run_to(29, "t1");  chk("t1.busy@29", {2'b0, busy_v[0]}, 3'b001);
        run_to(30, "t1");  chk("t1.o0@30", o0, 3'b111);
        chk("t1.done@30", {2'b0, done_v[0]}, 3'b001);
        run_to(49, "t3");
        sw_rst_req = 1'b1;
        run_to(50, "t3");
        sw_rst_req = 1'b0;
        chk("t3.o0@50", o0, 3'b000);
        run_to(66, "t3");  chk("t3.o0@66", o0, 3'b000);
        run_to(67, "t3");  chk("t3.o0@67", o0, 3'b001);
        run_to(72, "t3");  chk("t3.o0@72", o0, 3'b011);
        run_to(77, "t3");  chk("t3.o0@77", o0, 3'b111);

        // Async reset in the middle of the first gap.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        e = -1;
        run_to(22, "t4");
        rst_n = 1'b0;
        #1;
        chk("t4.async.o0", o0, 3'b000);
        check_all("t4.async");
        @(negedge clk);
        rst_n = 1'b1;
        e = -1;
        run_to(19, "t4");  chk("t4.o0@19", o0, 3'b000);
        run_to(20, "t4");  chk("t4.o0@20", o0, 3'b001);
        run_to(25, "t4");  chk("t4.o0@25", o0, 3'b011);
        run_to(30, "t4");  chk("t4.o0@30", o0, 3'b111);

        // Hold on channel 1 across edges 0..40.
        rst_n = 1'b0;
        step();
        ch_hold = 3'b010;
        rst_n = 1'b1;
        e = -1;
        run_to(20, "t2");  chk("t2.o0@20", o0, 3'b001);
        run_to(40, "t2");  chk("t2.o0@40", o0, 3'b001);
        ch_hold = 3'b000;
        run_to(41, "t2");  chk("t2.o0@41", o0, 3'b011);
        run_to(45, "t2");  chk("t2.o0@45", o0, 3'b011);
        run_to(46, "t2");  chk("t2.o0@46", o0, 3'b111);

        // DFT bypass: outputs follow rst_n with no clock involvement.
        test_mode = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("t5.bypass.low", o0, 3'b000);
        check_all("t5.low");
        rst_n = 1'b1;
        #1;
        chk("t5.bypass.high", o0, 3'b111);
        check_all("t5.high");
        @(negedge clk);
        e = -1;
        run_to(10, "t5");  chk("t5.o0@10", o0, 3'b111);
        run_to(30, "t5");
        test_mode = 1'b0;
        #1;
        chk("t5.registered", o0, 3'b111);

        // Randomised holds, re-resets, bypass and async resets.
        e = 0;
        repeat (3000) begin
            step();
            check_all("rnd");
            ch_hold    = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 2) == 0)};
            sw_rst_req = ($urandom_range(0, 79) == 0);
            test_mode  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #2;
                check_all("rnd.async");
            end else begin
                rst_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
